// File: rtl/config_pkg.sv
// Shared constants, types and FSM encoding for the irq_dispatch interrupt controller.
// Optional nested preemption is enabled by defining CLIC_NEST_EN.
package config_pkg;

    localparam int VecSize   = 8;
    localparam int PrioWidth = 3;
    localparam int NestDepth = 4;
    localparam int IdWidth   = $clog2(VecSize);

    typedef logic [IdWidth-1:0]   IrqIdT;
    typedef logic [PrioWidth-1:0] IrqPrioT;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACTIVE
    } IrqStateT;

endpackage

// File: rtl/prio_arbiter.sv
// Combinational selector: highest priority among eligible entries, lowest index on ties.
module prio_arbiter #(
    parameter int VecSize   = 8,
    parameter int PrioWidth = 3
) (
    input  logic [VecSize-1:0]         eligible,
    input  logic [PrioWidth-1:0]       prio [VecSize],
    output logic                       valid,
    output logic [$clog2(VecSize)-1:0] id,
    output logic [PrioWidth-1:0]       win_prio
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        valid    = 1'b0;
        id       = '0;
        win_prio = '0;
        // Ascending scan with strict '>' keeps the lowest index on equal priority.
        for (int i = 0; i < VecSize; i++) begin
            if (eligible[i] && (!valid || prio[i] > win_prio)) begin
                valid    = 1'b1;
                id       = ($clog2(VecSize))'(i);
                win_prio = prio[i];
            end
        end
    end

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: arbitrates level-held interrupt_set lines, requests the core and
// pulses interrupt_clear to the taken source. Define CLIC_NEST_EN for nested preemption.
module irq_dispatch
    import config_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [VecSize-1:0]   interrupt_set,
    output logic [VecSize-1:0]   interrupt_clear,
    input  logic                 cfg_we,
    input  logic [IdWidth-1:0]   cfg_idx,
    input  logic [PrioWidth-1:0] cfg_prio,
    input  logic                 cfg_en,
    output logic                 irq_req,
    output logic [IdWidth-1:0]   irq_id,
    output logic [PrioWidth-1:0] irq_prio,
    input  logic                 irq_ack,
    input  logic                 irq_done,
    output logic [PrioWidth-1:0] cur_level
);

    IrqPrioT            prio_q [VecSize];
    logic [VecSize-1:0] en_q;
    logic [VecSize-1:0] clr_prev;
    IrqStateT           state_q, state_d;

    logic               done_v, ack_v;
    IrqPrioT            level_after_done, cmp_level;
    logic [VecSize-1:0] eligible;
    logic               win_valid;
    IrqIdT              win_id;
    IrqPrioT            win_prio;

    logic               req_d;
    IrqIdT              id_d;
    IrqPrioT            prio_d, level_d;
    logic [VecSize-1:0] clr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q <= '0;
            for (int i = 0; i < VecSize; i++) prio_q[i] <= '0;
        end else if (cfg_we) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            prio_q[cfg_idx] <= cfg_prio;
            en_q[cfg_idx]   <= cfg_en;
        end
    end

`ifdef CLIC_NEST_EN
    localparam int DepthWidth = $clog2(NestDepth + 1);
    localparam int TopWidth   = $clog2(NestDepth);

    logic [DepthWidth-1:0] depth_q;
    IrqPrioT               stack_q [NestDepth];
    logic [TopWidth-1:0]   top_idx;
    logic                  stack_full, last_pop, push, pop;

    assign top_idx          = TopWidth'(depth_q - DepthWidth'(1));
    assign stack_full       = (depth_q == DepthWidth'(NestDepth));
    assign last_pop         = (depth_q == DepthWidth'(1));
    assign level_after_done = stack_q[top_idx];
    assign push             = ack_v;
    assign pop              = done_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     depth_q <= '0;
        else if (push) depth_q <= depth_q + DepthWidth'(1);
        else if (pop)  depth_q <= depth_q - DepthWidth'(1);
    end

    // NOTE: stack storage has no reset; depth_q alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push) stack_q[depth_q[TopWidth-1:0]] <= cur_level;
    end
`else
    assign level_after_done = '0;
`endif

    assign done_v = irq_done && (state_q == ACTIVE);
    assign ack_v  = irq_ack && irq_req && !done_v;

    // On the done cycle, compare against the level being returned to so a waiting
    // source is requested the very next cycle.
    assign cmp_level = done_v ? level_after_done : cur_level;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < VecSize; i++) begin
            eligible[i] = interrupt_set[i] && en_q[i] && (prio_q[i] > cmp_level)
                          && !interrupt_clear[i] && !clr_prev[i];
        end
    end

    prio_arbiter #(
        .VecSize   (VecSize),
        .PrioWidth (PrioWidth)
    ) u_arb (
        .eligible (eligible),
        .prio     (prio_q),
        .valid    (win_valid),
        .id       (win_id),
        .win_prio (win_prio)
    );

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            irq_req         <= 1'b0;
            irq_id          <= '0;
            irq_prio        <= '0;
            interrupt_clear <= '0;
            clr_prev        <= '0;
            cur_level       <= '0;
        end else begin
            state_q         <= state_d;
            irq_req         <= req_d;
            irq_id          <= id_d;
            irq_prio        <= prio_d;
            interrupt_clear <= clr_d;
            clr_prev        <= interrupt_clear;
            cur_level       <= level_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (win_valid) state_d = REQ;
            REQ: begin
                if (ack_v)           state_d = ACTIVE;
                else if (!win_valid) state_d = IDLE;
            end
            ACTIVE: begin
`ifdef CLIC_NEST_EN
                if (done_v && last_pop) state_d = win_valid ? REQ : IDLE;
`else
                if (done_v) state_d = win_valid ? REQ : IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        req_d   = 1'b0;
        id_d    = irq_id;
        prio_d  = irq_prio;
        clr_d   = '0;
        level_d = cur_level;

        if (ack_v) begin
            clr_d[irq_id] = 1'b1;
            level_d       = irq_prio;
        end else if (done_v) begin
            level_d = level_after_done;
            req_d   = win_valid;
        end else begin
            case (state_q)
                IDLE, REQ: req_d = win_valid;
`ifdef CLIC_NEST_EN
                ACTIVE:    req_d = win_valid && !stack_full;
`endif
                default:   req_d = 1'b0;
            endcase
        end

        if (req_d) begin
            id_d   = win_id;
            prio_d = win_prio;
        end
    end

endmodule
